dm_store_buffer: RTL
====================

Name: dm_store_buffer

Overview:
- Store buffer between the MEM-stage pipeline register and the data memory; owns the memory's single address/write port.
- Retires stores from MEM in one cycle and drains them into data memory when no load needs the port.
- Detects word-address conflicts between a load and pending stores, and stalls the load until the conflicting entries drain.

Parameters:
- DEPTH, 4, number of buffer entries; power of two, ≥2.
- PTR_W, 2, pointer width; must equal log2(DEPTH).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rstn  in  1  asynchronous active-low reset.
- st_valid  in  1  MEM stage presents a store.
- st_ready  out  1  buffer can accept a store this cycle.
- st_addr  in  32  store byte address.
- st_data  in  32  store data, right-aligned.
- st_type  in  3  access type: 000 word, 001 half, 011 byte.
- ld_valid  in  1  MEM stage presents a load.
- ld_addr  in  32  load byte address.
- ld_type  in  3  load type: 000/001/010/011/100.
- ld_stall  out  1  load conflicts with a pending store; hold the pipeline.
- ld_fwd  out  1  forwarded load data valid (STB_FWD_EN only).
- ld_fwd_data  out  32  forwarded word (STB_FWD_EN only).
- dm_wr  out  1  data-memory write enable.
- dm_addr  out  32  data-memory address.
- dm_din  out  32  data-memory write data.
- dm_type  out  3  data-memory access type.
- empty  out  1  no pending stores.
- count  out  PTR_W+1  number of pending entries, 0..DEPTH.

Behaviour:
- Storage: circular FIFO of {addr, data, type}, with wr_ptr, rd_ptr and count.
  - Pointers wrap modulo DEPTH.
  - count saturates at DEPTH by construction.
- Reset (rstn low, asynchronous): pointers = 0, count = 0, all entry valid state cleared.
  - Outputs during and after reset: st_ready = 1, empty = 1, dm_wr = 0, ld_stall = 0, ld_fwd = 0, ld_fwd_data = 0.
  - Reset mid-operation discards pending stores; no partial drain is completed.
- Enqueue:
  - st_ready = (count != DEPTH), purely from registered state; no combinational path from drain.
  - On posedge with st_valid && st_ready: write the entry at wr_ptr, then wr_ptr++.
  - st_type is stored unmodified. Types 010/100/1xx are passed through, and data memory treats them as word.
- Hazard detection:
  - hit = ld_valid && any pending entry has addr[31:2] == ld_addr[31:2]. Compare uses entries present before the current edge only.
  - ld_stall = hit, with the exception listed under STB_FWD_EN.
- Drain:
  - drain = (count != 0) && (!ld_valid || ld_stall).
  - dm_wr = drain (combinational).
  - Drain values: dm_addr/dm_din/dm_type = head entry.
  - On posedge with drain: rd_ptr++; data memory writes on the same edge.
  - When not draining: dm_addr = ld_addr, dm_type = ld_type, dm_din = 0. Load data memory read is valid the same cycle.
- Stall progress: while stalled, the buffer drains one entry per cycle. ld_stall drops the cycle after the last conflicting entry retires.
- Latency: store enqueue → memory write ≥ 1 cycle; exactly 1 cycle if no load is present.
- Simultaneous enqueue and drain: count unchanged; both pointers advance.
- Full: st_valid is held, and the store is accepted the cycle after count falls below DEPTH.
- st_valid and ld_valid asserted together (illegal in the pipeline): the store is accepted, and the load checks only older entries.
- Ordering: drains strictly FIFO; memory sees stores in program order.

Optional Feature:
- Macro STB_FWD_EN.
- Defined: if ld_type == 000 and the youngest matching entry has type 000 and the same addr[31:2]:
  - ld_stall = 0, ld_fwd = 1, ld_fwd_data = that entry's data.
  - No drain occurs that cycle.
  - Youngest = nearest to wr_ptr − 1, resolved by priority.
- Defined, any other hit: stall as normal.
- Undefined: ld_fwd and ld_fwd_data are constant 0, and all hits stall.

Test Plan:
- Reset, then sw 0x11223344 @0x10 with no loads → cycle 0 accepted; cycle 1 dm_wr=1, dm_addr=0x10, dm_din=0x11223344, dm_type=000; empty=1 after.
- Fill with 4 stores while ld_valid is held on a non-conflicting address 0x40 → count=4, st_ready=0, dm_wr=0; drop ld_valid → 4 consecutive drains in order, st_ready=1 after the first.
- sb 0xAB @0x21 pending, then lb @0x20 → ld_stall=1, dm_wr=1 for 1 cycle; next cycle ld_stall=0, dm_addr=0x20, dm_type=011.
- Store enqueue and drain on the same edge at count=2 → count stays 2; wr_ptr/rd_ptr wrap correctly from 3→0.
- rstn low for 1 cycle with count=3 → count=0, empty=1, dm_wr=0 immediately; no further writes.
- STB_FWD_EN: sw 0x1 @0x8 then sw 0x2 @0x8 pending, lw @0x8 → ld_fwd=1, ld_fwd_data=0x2, ld_stall=0. Without the macro → ld_stall=1 until both drain.

Source files
------------

// File: rtl/dm_store_buffer_if.sv
// Bus bundle for dm_store_buffer: MEM-stage store/load requests, data-memory port and status.
// master = pipeline/memory side, slave = the store buffer itself.
interface dm_store_buffer_if #(
   parameter int unsigned PTR_W = 2
);
   logic             st_valid;
   logic             st_ready;
   logic [31:0]      st_addr;
   logic [31:0]      st_data;
   logic [2:0]       st_type;
   logic             ld_valid;
   logic [31:0]      ld_addr;
   logic [2:0]       ld_type;
   logic             ld_stall;
   logic             ld_fwd;
   logic [31:0]      ld_fwd_data;
   logic             dm_wr;
   logic [31:0]      dm_addr;
   logic [31:0]      dm_din;
   logic [2:0]       dm_type;
   logic             empty;
   logic [PTR_W:0]   count;

   modport master (
      output st_valid, st_addr, st_data, st_type, ld_valid, ld_addr, ld_type,
      input  st_ready, ld_stall, ld_fwd, ld_fwd_data, dm_wr, dm_addr, dm_din, dm_type,
             empty, count
   );

   modport slave (
      input  st_valid, st_addr, st_data, st_type, ld_valid, ld_addr, ld_type,
      output st_ready, ld_stall, ld_fwd, ld_fwd_data, dm_wr, dm_addr, dm_din, dm_type,
             empty, count
   );
endinterface

// File: rtl/dm_store_buffer.sv
// Store buffer owning the data-memory port: FIFO of retired stores, drained when no load needs the port.
// Optional macro STB_FWD_EN: word loads hitting a youngest word store are forwarded instead of stalled.
module dm_store_buffer #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned PTR_W = 2
) (
   input logic              clk,
   input logic              rstn,
   dm_store_buffer_if.slave bus
);
   logic [31:0]      addr_q [DEPTH];
   logic [31:0]      data_q [DEPTH];
   logic [2:0]       type_q [DEPTH];
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]   count_q, count_d;
   logic             enq, drain, hit, fwd;
   logic [31:0]      fwd_data;

   assign bus.st_ready = (count_q != (PTR_W+1)'(DEPTH));
   assign bus.empty    = (count_q == '0);
   assign bus.count    = count_q;
   assign enq          = bus.st_valid && bus.st_ready;

   // Only entries present before this edge take part; a same-cycle store is not yet valid.
   always_comb begin
      hit = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && (addr_q[i][31:2] == bus.ld_addr[31:2])) hit = 1'b1;
      end
      hit = hit && bus.ld_valid;
   end

`ifdef STB_FWD_EN
   logic             fwd_found;
   logic [PTR_W-1:0] fwd_idx;

   // Walk from wr_ptr-1 backwards so the first match is the youngest store to that word.
   always_comb begin
      fwd_found = 1'b0;
      fwd_idx   = '0;
      fwd       = 1'b0;
      fwd_data  = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         fwd_idx = wr_ptr_q - PTR_W'(1) - PTR_W'(i);
         if (!fwd_found && valid_q[fwd_idx] && (addr_q[fwd_idx][31:2] == bus.ld_addr[31:2])) begin
            fwd_found = 1'b1;
            fwd       = bus.ld_valid && (bus.ld_type == 3'b000) && (type_q[fwd_idx] == 3'b000);
            fwd_data  = data_q[fwd_idx];
         end
      end
      if (!fwd) fwd_data = '0;
   end
`else
   assign fwd      = 1'b0;
   assign fwd_data = '0;
`endif

   assign bus.ld_stall    = hit && !fwd;
   assign bus.ld_fwd      = fwd;
   assign bus.ld_fwd_data = fwd_data;
   assign drain           = (count_q != '0) && (!bus.ld_valid || bus.ld_stall);

   always_comb begin
      bus.dm_wr   = drain;
      bus.dm_addr = bus.ld_addr;
      bus.dm_din  = '0;
      bus.dm_type = bus.ld_type;
      if (drain) begin
         bus.dm_addr = addr_q[rd_ptr_q];
         bus.dm_din  = data_q[rd_ptr_q];
         bus.dm_type = type_q[rd_ptr_q];
      end
   end

   always_comb begin
      valid_d = valid_q;
      if (drain) valid_d[rd_ptr_q] = 1'b0;
      if (enq)   valid_d[wr_ptr_q] = 1'b1;
      count_d = count_q;
      case ({enq, drain})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= '0;
      end else begin
         if (enq)   wr_ptr_q <= wr_ptr_q + 1'b1;
         if (drain) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
         valid_q <= valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         addr_q[wr_ptr_q] <= bus.st_addr;
         data_q[wr_ptr_q] <= bus.st_data;
         type_q[wr_ptr_q] <= bus.st_type;
      end
   end
endmodule
